// File: rtl/multi_channel_sampler.sv
// Periodic sample-and-hold bank: a programmable rollover counter strobes
// per-channel masked captures in OFF, PERIODIC, ONE_SHOT or CONTINUOUS mode.
module multi_channel_sampler #(
  parameter int WIDTH = 4,
  parameter int CH    = 2,
  parameter int CNT_W = 3
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [CNT_W-1:0]      period,
  input  logic                  start,
  input  logic [CH-1:0]         ch_mask,
  input  logic [CH*WIDTH-1:0]   val_in,
  output logic [CH*WIDTH-1:0]   val_out,
  output logic [CNT_W-1:0]      cnt,
  output logic                  roll,
  output logic                  smp_vld,
  output logic                  busy
);

  typedef enum logic [1:0] {
    MODE_OFF      = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_ONE_SHOT = 2'b10,
    MODE_CONT     = 2'b11
  } mode_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  mode_t            mode_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             mode_chg;
  logic             cmp_hit;
  logic             active;

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state   <= IDLE;
      mode_q  <= MODE_OFF;
      cnt     <= '0;
      smp_vld <= 1'b0;
    end else begin
      state   <= state_nxt;
      mode_q  <= mode_t'(mode);
      cnt     <= cnt_nxt;
      smp_vld <= roll;
    end
  end

  // A mode change costs one dead cycle: counter and FSM restart, no capture.
  always_comb begin
    mode_chg  = (mode != mode_q);
    cmp_hit   = (cnt >= period);
    active    = 1'b0;
    roll      = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;

    case (mode_q)
      MODE_PERIODIC: begin
        active = en;
        roll   = en && cmp_hit;
      end
      MODE_ONE_SHOT: begin
        active = en && (state == RUN);
        roll   = active && cmp_hit;
      end
      MODE_CONT: begin
        active = en;
        roll   = en;
      end
      default: ;
    endcase

    if (mode_chg || mode_q == MODE_OFF) begin
      roll      = 1'b0;
      cnt_nxt   = '0;
      state_nxt = IDLE;
    end else begin
      if (active)
        cnt_nxt = cmp_hit ? '0 : cnt + CNT_W'(1);
      if (mode_q == MODE_ONE_SHOT) begin
        if (state == IDLE && start && en) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (state == RUN && roll) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  // Masked channels keep their previous sample across a strobe.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      val_out <= '0;
    end else if (roll) begin
      for (int i = 0; i < CH; i++) begin
        if (ch_mask[i])
          val_out[i*WIDTH +: WIDTH] <= val_in[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_sampler.sv
// Directed testbench for multi_channel_sampler with hand-computed expectations.
module tb_multi_channel_sampler;

  logic       clk = 1'b0;
  logic       res_n;
  logic       en;
  logic [1:0] mode;
  logic [2:0] period;
  logic       start;
  logic [1:0] ch_mask;
  logic [7:0] val_in;
  logic [7:0] val_out;
  logic [2:0] cnt;
  logic       roll;
  logic       smp_vld;
  logic       busy;

  int tests  = 0;
  int failed = 0;

  multi_channel_sampler #(.WIDTH(4), .CH(2), .CNT_W(3)) dut (
    .clk     (clk),
    .res_n   (res_n),
    .en      (en),
    .mode    (mode),
    .period  (period),
    .start   (start),
    .ch_mask (ch_mask),
    .val_in  (val_in),
    .val_out (val_out),
    .cnt     (cnt),
    .roll    (roll),
    .smp_vld (smp_vld),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 2 time units after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    res_n = 1'b0; en = 1'b1; mode = 2'b01; period = 3'd7; start = 1'b0;
    ch_mask = 2'b11; val_in = 8'hA5;
    tick(2);
    tests++; if (val_out !== 8'h00) begin failed++; $display("[TB] FAIL reset_val_out got %h want 00", val_out); end
    tests++; if (cnt !== 3'd0) begin failed++; $display("[TB] FAIL reset_cnt got %0d want 0", cnt); end
    tests++; if (smp_vld !== 1'b0) begin failed++; $display("[TB] FAIL reset_smp_vld got %b want 0", smp_vld); end
    tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_periodic;
    res_n = 1'b1;
    // First edge is the OFF->PERIODIC mode change, then counting 1..7.
    for (int k = 1; k <= 8; k++) begin
      tick();
      tests++; if (cnt !== 3'(k - 1)) begin failed++; $display("[TB] FAIL per_cnt k=%0d got %0d want %0d", k, cnt, k - 1); end
      tests++; if (val_out !== 8'h00) begin failed++; $display("[TB] FAIL per_hold k=%0d got %h want 00", k, val_out); end
      tests++; if (roll !== (k == 8)) begin failed++; $display("[TB] FAIL per_roll k=%0d got %b want %b", k, roll, (k == 8)); end
    end
    tick();
    tests++; if (val_out !== 8'hA5) begin failed++; $display("[TB] FAIL per_capture got %h want a5", val_out); end
    tests++; if (smp_vld !== 1'b1) begin failed++; $display("[TB] FAIL per_vld got %b want 1", smp_vld); end
    tests++; if (cnt !== 3'd0) begin failed++; $display("[TB] FAIL per_wrap got %0d want 0", cnt); end
    val_in = 8'h3C;
    tick(7);
    tests++; if (smp_vld !== 1'b0 || val_out !== 8'hA5) begin failed++; $display("[TB] FAIL per_gap got vld=%b val=%h want 0/a5", smp_vld, val_out); end
    tick();
    tests++; if (smp_vld !== 1'b1 || val_out !== 8'h3C) begin failed++; $display("[TB] FAIL per_second got vld=%b val=%h want 1/3c", smp_vld, val_out); end
  endtask

  task automatic test_period_shrink;
    tick(6);
    tests++; if (cnt !== 3'd6) begin failed++; $display("[TB] FAIL shrink_pre_cnt got %0d want 6", cnt); end
    period = 3'd3;
    #1;
    tests++; if (roll !== 1'b1) begin failed++; $display("[TB] FAIL shrink_roll got %b want 1", roll); end
    tick();
    tests++; if (smp_vld !== 1'b1 || cnt !== 3'd0) begin failed++; $display("[TB] FAIL shrink_capture got vld=%b cnt=%0d want 1/0", smp_vld, cnt); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests++; if (smp_vld !== (k == 4)) begin failed++; $display("[TB] FAIL shrink_rate k=%0d got %b want %b", k, smp_vld, (k == 4)); end
    end
    period = 3'd0;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests++; if (smp_vld !== 1'b1 || cnt !== 3'd0) begin failed++; $display("[TB] FAIL period0 k=%0d got vld=%b cnt=%0d want 1/0", k, smp_vld, cnt); end
    end
  endtask

  task automatic test_masking;
    period = 3'd3; val_in = 8'h12;
    tick(4);
    tests++; if (val_out !== 8'h12 || smp_vld !== 1'b1) begin failed++; $display("[TB] FAIL mask_full got %h vld=%b want 12/1", val_out, smp_vld); end
    ch_mask = 2'b01; val_in = 8'h34;
    tick(4);
    tests++; if (val_out !== 8'h14 || smp_vld !== 1'b1) begin failed++; $display("[TB] FAIL mask_lo got %h vld=%b want 14/1", val_out, smp_vld); end
    ch_mask = 2'b00; val_in = 8'h56;
    tick(4);
    tests++; if (val_out !== 8'h14 || smp_vld !== 1'b1) begin failed++; $display("[TB] FAIL mask_none got %h vld=%b want 14/1", val_out, smp_vld); end
    ch_mask = 2'b11;
  endtask

  task automatic test_enable_mode;
    period = 3'd7; val_in = 8'h77;
    tick(4);
    tests++; if (cnt !== 3'd4) begin failed++; $display("[TB] FAIL en_pre_cnt got %0d want 4", cnt); end
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++; if (cnt !== 3'd4 || val_out !== 8'h14 || smp_vld !== 1'b0) begin failed++; $display("[TB] FAIL en_hold k=%0d got cnt=%0d val=%h vld=%b want 4/14/0", k, cnt, val_out, smp_vld); end
    end
    en = 1'b1; mode = 2'b11;
    #1;
    tests++; if (roll !== 1'b0) begin failed++; $display("[TB] FAIL modechg_roll got %b want 0", roll); end
    tick();
    tests++; if (cnt !== 3'd0 || smp_vld !== 1'b0 || val_out !== 8'h14) begin failed++; $display("[TB] FAIL modechg_edge got cnt=%0d vld=%b val=%h want 0/0/14", cnt, smp_vld, val_out); end
    val_in = 8'h9B;
    tick();
    tests++; if (val_out !== 8'h9B || smp_vld !== 1'b1 || cnt !== 3'd1) begin failed++; $display("[TB] FAIL cont_1 got val=%h vld=%b cnt=%0d want 9b/1/1", val_out, smp_vld, cnt); end
    val_in = 8'h7E;
    tick();
    tests++; if (val_out !== 8'h7E || smp_vld !== 1'b1 || cnt !== 3'd2) begin failed++; $display("[TB] FAIL cont_2 got val=%h vld=%b cnt=%0d want 7e/1/2", val_out, smp_vld, cnt); end
  endtask

  task automatic test_one_shot;
    mode = 2'b10; period = 3'd2; val_in = 8'hC3;
    tick();
    tests++; if (busy !== 1'b0 || cnt !== 3'd0) begin failed++; $display("[TB] FAIL os_enter got busy=%b cnt=%0d want 0/0", busy, cnt); end
    en = 1'b0; start = 1'b1;
    tick();
    tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL os_start_en0 got %b want 0", busy); end
    en = 1'b1; start = 1'b0;
    tick();
    tests++; if (busy !== 1'b0 || smp_vld !== 1'b0) begin failed++; $display("[TB] FAIL os_idle got busy=%b vld=%b want 0/0", busy, smp_vld); end
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if (busy !== 1'b1 || cnt !== 3'(k) || smp_vld !== 1'b0) begin failed++; $display("[TB] FAIL os_run k=%0d got busy=%b cnt=%0d vld=%b want 1/%0d/0", k, busy, cnt, smp_vld, k); end
    end
    tests++; if (roll !== 1'b1) begin failed++; $display("[TB] FAIL os_roll got %b want 1", roll); end
    tick();
    tests++; if (val_out !== 8'hC3 || smp_vld !== 1'b1 || busy !== 1'b0 || cnt !== 3'd0) begin failed++; $display("[TB] FAIL os_capture got val=%h vld=%b busy=%b cnt=%0d want c3/1/0/0", val_out, smp_vld, busy, cnt); end
    start = 1'b0; val_in = 8'h11;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++; if (busy !== 1'b0 || smp_vld !== 1'b0 || val_out !== 8'hC3) begin failed++; $display("[TB] FAIL os_after k=%0d got busy=%b vld=%b val=%h want 0/0/c3", k, busy, smp_vld, val_out); end
    end
  endtask

  task automatic test_reset_mid;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tests++; if (busy !== 1'b1 || cnt !== 3'd1) begin failed++; $display("[TB] FAIL rst_pre got busy=%b cnt=%0d want 1/1", busy, cnt); end
    res_n = 1'b0;
    tick();
    tests++; if (val_out !== 8'h00 || cnt !== 3'd0 || smp_vld !== 1'b0 || busy !== 1'b0) begin failed++; $display("[TB] FAIL rst_mid got val=%h cnt=%0d vld=%b busy=%b want 00/0/0/0", val_out, cnt, smp_vld, busy); end
    res_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      tests++; if (busy !== 1'b0 || smp_vld !== 1'b0 || val_out !== 8'h00) begin failed++; $display("[TB] FAIL rst_after k=%0d got busy=%b vld=%b val=%h want 0/0/00", k, busy, smp_vld, val_out); end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_period_shrink();
    test_masking();
    test_enable_mode();
    test_one_shot();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
